imm_table: RTL and testbench

- Parametrised, writable successor to the fixed immediate lookup table.
- Holds DEPTH immediates of DATA_W bits in registers.
- After reset, or on request, a sweep state machine loads the canonical default immediate set.
- Serves registered reads with a valid/ready handshake to the decode stage; a single write port lets the control unit patch entries at run time.

---
 rtl/imm_pkg.sv | 27 ++
 rtl/imm_init_seq.sv | 70 +++++++
 rtl/imm_table.sv | 152 +++++++++++++++
 tb/tb_imm_table.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared types and the canonical default immediate set for imm_table.
package imm_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;

  localparam int IMM_DEFAULT_CNT = 24;

  localparam logic [0:IMM_DEFAULT_CNT-1][7:0] IMM_DEFAULTS = '{
    8'd0,   8'd1,   8'd2,   8'd3,   8'd4,   8'd5,   8'd6,   8'd14,
    8'd16,  8'd30,  8'd31,  8'd32,  8'd33,  8'd60,  8'd91,  8'd109,
    8'd142, 8'd170, 8'd204, 8'd224, 8'd225, 8'd240, 8'd247, 8'd254
  };

  function automatic logic [7:0] imm_default(input logic [31:0] idx);
    logic [7:0] val_s;
    if (idx < 32'(IMM_DEFAULT_CNT)) begin
      val_s = IMM_DEFAULTS[idx[4:0]];
    end else begin
      val_s = 8'd0;
    end
    return val_s;
  endfunction

endpackage

// File: rtl/imm_init_seq.sv
// Sweep counter and INIT/IDLE control for imm_table; INIT writes one default entry per cycle.
module imm_init_seq
  import imm_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restore_req,
  output state_t           state,
  output logic             busy,
  output logic             sweep_we,
  output logic [IDX_W-1:0] sweep_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [IDX_W-1:0] cnt_r;
  logic [IDX_W-1:0] cnt_nxt_s;

  // State and sweep counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= INIT;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic; a restore request always restarts the sweep at entry 0
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      INIT: begin
        if (restore_req) begin
          cnt_nxt_s = '0;
        end else if (cnt_r == LAST_IDX) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s = cnt_r + IDX_W'(1);
        end
      end
      IDLE: begin
        if (restore_req) begin
          state_nxt_s = INIT;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = INIT;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  assign state     = state_r;
  assign busy      = (state_r == INIT);
  assign sweep_we  = (state_r == INIT);
  assign sweep_idx = cnt_r;

endmodule

// File: rtl/imm_table.sv
// Writable immediate table with registered valid/ready reads and a default-restore sweep.
// Optional even-parity protection per entry is enabled with IMM_TABLE_PARITY_EN.
module imm_table
  import imm_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 8,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restore_req,
  output logic              busy,
  input  logic              rd_req,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
`ifdef IMM_TABLE_PARITY_EN
  input  logic              inj_perr,
`endif
  output logic              wr_ack,
  output logic              rd_perr
);

  localparam logic [IDX_W:0] DEPTH_X = (IDX_W + 1)'(DEPTH);

  state_t            state_s;
  logic              sweep_we_s;
  logic [IDX_W-1:0]  sweep_idx_s;
  logic [DATA_W-1:0] sweep_data_s;
  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              idle_s;
  logic              rd_acc_s;
  logic              rd_inr_s;
  logic              wr_inr_s;
  logic              wr_ok_s;
  logic              fwd_s;
  logic [DATA_W-1:0] rd_word_s;
  logic              rd_par_bad_s;

  logic              rd_valid_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              rd_err_r;
  logic              rd_perr_r;
  logic              wr_ack_r;

  imm_init_seq #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_init_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .restore_req (restore_req),
    .state       (state_s),
    .busy        (busy),
    .sweep_we    (sweep_we_s),
    .sweep_idx   (sweep_idx_s)
  );

  assign sweep_data_s = DATA_W'(imm_default(32'(sweep_idx_s)));
  assign idle_s       = (state_s == IDLE);
  assign rd_acc_s     = rd_req && idle_s;
  assign rd_inr_s     = ({1'b0, rd_idx} < DEPTH_X);
  assign wr_inr_s     = ({1'b0, wr_idx} < DEPTH_X);
  // A restore in the same cycle wins over a write
  assign wr_ok_s      = wr_en && idle_s && wr_inr_s && !restore_req;
  assign fwd_s        = wr_ok_s && (wr_idx == rd_idx);

`ifdef IMM_TABLE_PARITY_EN
  logic par_r [DEPTH];
  logic wr_par_s;
  logic stored_par_s;

  function automatic logic parity_even(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  assign wr_par_s = parity_even(wr_data) ^ inj_perr;

  // Parity storage alongside the data array
  always_ff @(posedge clk) begin
    if (sweep_we_s) begin
      par_r[sweep_idx_s] <= parity_even(sweep_data_s);
    end else if (wr_ok_s) begin
      par_r[wr_idx] <= wr_par_s;
    end
  end
`endif

  // Table array; contents are defined only once a sweep has written them
  always_ff @(posedge clk) begin
    if (sweep_we_s) begin
      mem_r[sweep_idx_s] <= sweep_data_s;
    end else if (wr_ok_s) begin
      mem_r[wr_idx] <= wr_data;
    end
  end

  // Read mux with write-first forwarding and parity recheck
  always_comb begin
    rd_word_s    = '0;
    rd_par_bad_s = 1'b0;
    if (!rd_inr_s) begin
      rd_word_s = '0;
    end else if (fwd_s) begin
      rd_word_s = wr_data;
    end else begin
      rd_word_s = mem_r[rd_idx];
    end
`ifdef IMM_TABLE_PARITY_EN
    stored_par_s = fwd_s ? wr_par_s : par_r[rd_idx];
    if (rd_inr_s) begin
      rd_par_bad_s = (parity_even(rd_word_s) != stored_par_s);
    end else begin
      rd_par_bad_s = 1'b0;
    end
`endif
  end

  // Registered read response and write acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
      rd_err_r   <= 1'b0;
      rd_perr_r  <= 1'b0;
      wr_ack_r   <= 1'b0;
    end else begin
      rd_valid_r <= rd_acc_s;
      rd_err_r   <= rd_acc_s && !rd_inr_s;
      rd_perr_r  <= rd_acc_s && rd_par_bad_s;
      wr_ack_r   <= wr_ok_s;
      if (rd_acc_s) begin
        rd_data_r <= rd_word_s;
      end
    end
  end

  assign rd_ready = idle_s;
  assign rd_valid = rd_valid_r;
  assign rd_data  = rd_data_r;
  assign rd_err   = rd_err_r;
  assign rd_perr  = rd_perr_r;
  assign wr_ack   = wr_ack_r;

endmodule

// File: tb/tb_imm_table.sv
// Bench for imm_table: DEPTH=32 and DEPTH=20 instances share stimulus; vectors, sequences and random traffic.
module tb_imm_table;

  logic       clk;
  logic       rst_n;
  logic       restore_req;
  logic       rd_req;
  logic [4:0] rd_idx;
  logic       wr_en;
  logic [4:0] wr_idx;
  logic [7:0] wr_data;
  logic       inj_perr;

  logic       busy_a, rd_ready_a, rd_valid_a, rd_err_a, wr_ack_a, rd_perr_a;
  logic [7:0] rd_data_a;
  logic       busy_b, rd_ready_b, rd_valid_b, rd_err_b, wr_ack_b, rd_perr_b;
  logic [7:0] rd_data_b;

  int checks = 0;
  int errors = 0;

  imm_table #(.DEPTH(32), .DATA_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .restore_req(restore_req), .busy(busy_a),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_ready(rd_ready_a), .rd_valid(rd_valid_a),
    .rd_data(rd_data_a), .rd_err(rd_err_a), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_data(wr_data),
`ifdef IMM_TABLE_PARITY_EN
    .inj_perr(inj_perr),
`endif
    .wr_ack(wr_ack_a), .rd_perr(rd_perr_a)
  );

  imm_table #(.DEPTH(20), .DATA_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .restore_req(restore_req), .busy(busy_b),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_ready(rd_ready_b), .rd_valid(rd_valid_b),
    .rd_data(rd_data_b), .rd_err(rd_err_b), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_data(wr_data),
`ifdef IMM_TABLE_PARITY_EN
    .inj_perr(inj_perr),
`endif
    .wr_ack(wr_ack_b), .rd_perr(rd_perr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per instance, table contents, a busy countdown and expected outputs
  int  defs [24] = '{0, 1, 2, 3, 4, 5, 6, 14, 16, 30, 31, 32, 33, 60, 91, 109,
                     142, 170, 204, 224, 225, 240, 247, 254};
  int  dep_m [2] = '{32, 20};
  int  mem_m [2][32];
  bit  perr_m [2][32];
  bit  busy_m [2];
  int  left_m [2];
  bit  exp_valid [2];
  int  exp_data [2];
  bit  exp_err [2];
  bit  exp_ack [2];
  bit  exp_perr [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      busy_m[k] = 1'b1; left_m[k] = dep_m[k];
      exp_valid[k] = 1'b0; exp_data[k] = 0; exp_err[k] = 1'b0;
      exp_ack[k] = 1'b0; exp_perr[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit acc, wok;
      acc = rd_req && !busy_m[k];
      wok = wr_en && !busy_m[k] && (int'(wr_idx) < dep_m[k]) && !restore_req;
      exp_valid[k] = acc; exp_err[k] = 1'b0; exp_perr[k] = 1'b0;
      if (acc) begin
        if (int'(rd_idx) >= dep_m[k]) begin
          exp_data[k] = 0; exp_err[k] = 1'b1;
        end else if (wok && wr_idx == rd_idx) begin
          exp_data[k] = int'(wr_data); exp_perr[k] = inj_perr;
        end else begin
          exp_data[k] = mem_m[k][rd_idx]; exp_perr[k] = perr_m[k][rd_idx];
        end
      end
      exp_ack[k] = wok;
      if (wok) begin
        mem_m[k][wr_idx] = int'(wr_data); perr_m[k][wr_idx] = inj_perr;
      end
      if (restore_req) begin
        busy_m[k] = 1'b1; left_m[k] = dep_m[k];
      end else if (busy_m[k]) begin
        left_m[k]--;
        if (left_m[k] == 0) begin
          busy_m[k] = 1'b0;
          for (int i = 0; i < 32; i++) begin
            mem_m[k][i] = (i < 24) ? defs[i] : 0; perr_m[k][i] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic cmp_inst(input string t, input int k, input logic bz, input logic rdy,
                          input logic v, input logic [7:0] d, input logic e,
                          input logic a, input logic p);
    chk({t, "_busy"}, bz, busy_m[k]);
    chk({t, "_rd_ready"}, rdy, !busy_m[k]);
    chk({t, "_rd_valid"}, v, exp_valid[k]);
    chk({t, "_rd_data"}, d, exp_data[k]);
    chk({t, "_rd_err"}, e, exp_err[k]);
    chk({t, "_wr_ack"}, a, exp_ack[k]);
    chk({t, "_rd_perr"}, p, exp_perr[k]);
  endtask

  task automatic cmp_all();
    cmp_inst("d32", 0, busy_a, rd_ready_a, rd_valid_a, rd_data_a, rd_err_a, wr_ack_a, rd_perr_a);
    cmp_inst("d20", 1, busy_b, rd_ready_b, rd_valid_b, rd_data_b, rd_err_b, wr_ack_b, rd_perr_b);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  task automatic idle_in();
    restore_req = 1'b0; rd_req = 1'b0; rd_idx = 5'd0;
    wr_en = 1'b0; wr_idx = 5'd0; wr_data = 8'd0; inj_perr = 1'b0;
  endtask

  task automatic drive(input bit rd, input logic [4:0] ri, input bit wr,
                       input logic [4:0] wi, input logic [7:0] wd);
    rd_req = rd; rd_idx = ri; wr_en = wr; wr_idx = wi; wr_data = wd;
  endtask

  // Asynchronous reset in mid-cycle, checked before the next clock edge
  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    cmp_all();
    chk("rst_busy", busy_a, 1'b1);
    chk("rst_rd_ready", rd_ready_a, 1'b0);
    chk("rst_rd_data", rd_data_a, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic count_busy(input string nm, input int start, input int expect_n);
    int n;
    n = start;
    while (busy_a && n < 200) begin
      tick();
      n++;
    end
    chk(nm, n, expect_n);
  endtask

  typedef struct {
    bit         rd;
    logic [4:0] ri;
    bit         wr;
    logic [4:0] wi;
    logic [7:0] wd;
    bit         ev;
    logic [7:0] ed;
    bit         ea;
  } vec_t;

  vec_t vecs [12];

  initial begin
    rst_n = 1'b0;
    idle_in();
    model_reset();

    vecs[0]  = '{1'b1, 5'd7,  1'b0, 5'd0, 8'h00, 1'b1, 8'd14,  1'b0};
    vecs[1]  = '{1'b1, 5'd16, 1'b0, 5'd0, 8'h00, 1'b1, 8'd142, 1'b0};
    vecs[2]  = '{1'b1, 5'd23, 1'b0, 5'd0, 8'h00, 1'b1, 8'd254, 1'b0};
    vecs[3]  = '{1'b1, 5'd31, 1'b0, 5'd0, 8'h00, 1'b1, 8'd0,   1'b0};
    vecs[4]  = '{1'b0, 5'd0,  1'b1, 5'd5, 8'hA5, 1'b0, 8'd0,   1'b1};
    vecs[5]  = '{1'b1, 5'd5,  1'b0, 5'd0, 8'h00, 1'b1, 8'hA5,  1'b0};
    vecs[6]  = '{1'b1, 5'd9,  1'b1, 5'd9, 8'h3C, 1'b1, 8'h3C,  1'b1};
    vecs[7]  = '{1'b1, 5'd0,  1'b0, 5'd0, 8'h00, 1'b1, 8'd0,   1'b0};
    vecs[8]  = '{1'b1, 5'd1,  1'b0, 5'd0, 8'h00, 1'b1, 8'd1,   1'b0};
    vecs[9]  = '{1'b1, 5'd2,  1'b0, 5'd0, 8'h00, 1'b1, 8'd2,   1'b0};
    vecs[10] = '{1'b1, 5'd3,  1'b0, 5'd0, 8'h00, 1'b1, 8'd3,   1'b0};
    vecs[11] = '{1'b0, 5'd0,  1'b0, 5'd0, 8'h00, 1'b0, 8'd3,   1'b0};

    #2;
    do_reset();
    count_busy("init_sweep_cycles", 0, 32);
    chk("init_rd_ready", rd_ready_a, 1'b1);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rd, vecs[i].ri, vecs[i].wr, vecs[i].wi, vecs[i].wd);
      tick();
      chk($sformatf("vec%0d_valid", i), rd_valid_a, vecs[i].ev);
      chk($sformatf("vec%0d_data", i), rd_data_a, vecs[i].ed);
      chk($sformatf("vec%0d_ack", i), wr_ack_a, vecs[i].ea);
    end

    // Out-of-range read and write on the 20-entry instance
    drive(1'b1, 5'd25, 1'b0, 5'd0, 8'h00);
    tick();
    chk("oor_rd_valid", rd_valid_b, 1'b1);
    chk("oor_rd_data", rd_data_b, 8'd0);
    chk("oor_rd_err", rd_err_b, 1'b1);
    drive(1'b0, 5'd0, 1'b1, 5'd25, 8'h77);
    tick();
    chk("oor_wr_ack", wr_ack_b, 1'b0);
    chk("inr_wr_ack", wr_ack_a, 1'b1);

    // Overwrite, restore, dropped write during the sweep, defaults back
    drive(1'b0, 5'd0, 1'b1, 5'd13, 8'hFF);
    tick();
    drive(1'b1, 5'd13, 1'b0, 5'd0, 8'h00);
    tick();
    chk("ovr_rd_data", rd_data_a, 8'hFF);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 8'h00);
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    drive(1'b0, 5'd0, 1'b1, 5'd4, 8'h99);
    tick();
    chk("busy_wr_ack", wr_ack_a, 1'b0);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 8'h00);
    count_busy("restore_sweep_cycles", 1, 32);
    drive(1'b1, 5'd13, 1'b0, 5'd0, 8'h00);
    tick();
    chk("restored_idx13", rd_data_a, 8'd60);
    drive(1'b1, 5'd4, 1'b0, 5'd0, 8'h00);
    tick();
    chk("dropped_idx4", rd_data_a, 8'd4);

    // Reset in the middle of a read response
    drive(1'b1, 5'd7, 1'b0, 5'd0, 8'h00);
    tick();
    idle_in();
    do_reset();
    chk("rst_mid_read_valid", rd_valid_a, 1'b0);
    count_busy("post_reset_sweep", 0, 32);

    // Reset at sweep cycle 10 restarts the full sweep
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    do_reset();
    count_busy("mid_sweep_reset_cycles", 0, 32);

`ifdef IMM_TABLE_PARITY_EN
    drive(1'b0, 5'd0, 1'b1, 5'd2, 8'h5A);
    inj_perr = 1'b1;
    tick();
    inj_perr = 1'b0;
    drive(1'b1, 5'd2, 1'b0, 5'd0, 8'h00);
    tick();
    chk("perr_flag", rd_perr_a, 1'b1);
    chk("perr_data", rd_data_a, 8'h5A);
`endif

    // Random traffic checked against the model
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom));
      restore_req = ($urandom_range(0, 149) == 0);
`ifdef IMM_TABLE_PARITY_EN
      inj_perr = ($urandom_range(0, 7) == 0);
`endif
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
